// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding for the transmitter arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_SEND      = 2'd1,
        ARB_WAIT_DONE = 2'd2
    } uart_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int  NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               found,
    output logic [IW-1:0]      idx
);

    logic [NUM_REQ-1:0] hit;
    logic [IW-1:0]      cand [NUM_REQ];

    // cand[k] is the requester k places after ptr in scan order
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand[gi] = IW'((int'(ptr) + gi) % NUM_REQ);
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams;
// grants last one packet, capped by a burst limit and an idle-hold timeout.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int  NUM_REQ      = 4,
    parameter int  MAX_BURST    = 16,
    parameter int  HOLD_TIMEOUT = 1024,
    localparam int IW           = $clog2(NUM_REQ),
    localparam int BW           = $clog2(MAX_BURST + 1),
    localparam int HW           = $clog2(HOLD_TIMEOUT)
) (
    input  logic                   ifclk,
    input  logic                   resetb,
    input  logic                   enable,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   we,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic                   grant_valid,
    output logic [IW-1:0]          grant_id,
    output logic                   timeout_pulse
);

    uart_arb_state_t state_q, state_d;
    logic [IW-1:0]   g_q, g_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            last_q, last_d;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   g_wrap;
    logic            valid_g;
    logic            fire;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign valid_g = req_valid[g_q];
    // The releasing requester becomes the lowest priority on the next scan
    assign g_wrap  = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        g_d           = g_q;
        rr_ptr_d      = rr_ptr_q;
        burst_cnt_d   = burst_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        last_d        = last_q;
        fire          = 1'b0;
        timeout_pulse = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (enable && pick_found) begin
                    g_d         = pick_idx;
                    burst_cnt_d = '0;
                    hold_cnt_d  = '0;
                    state_d     = ARB_SEND;
                end
            end
            ARB_SEND: begin
                if (valid_g && !tx_busy) begin
                    fire        = 1'b1;
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    last_d      = req_last[g_q];
                    state_d     = ARB_WAIT_DONE;
                end else if (!valid_g) begin
                    if (hold_cnt_q == HW'(HOLD_TIMEOUT - 1)) begin
                        timeout_pulse = 1'b1;
                        rr_ptr_d      = g_wrap;
                        state_d       = ARB_IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            ARB_WAIT_DONE: begin
                if (tx_done) begin
                    if (last_q || (burst_cnt_q == BW'(MAX_BURST)) || !enable) begin
                        rr_ptr_d = g_wrap;
                        state_d  = ARB_IDLE;
                    end else begin
                        hold_cnt_d = '0;
                        state_d    = ARB_SEND;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ARB_IDLE;
            g_q         <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            hold_cnt_q  <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            last_q      <= last_d;
        end
    end

    assign we          = fire;
    assign grant_valid = (state_q != ARB_IDLE);
    assign grant_id    = g_q;
    assign tx_data     = (state_q == ARB_SEND) ? req_data[8*g_q +: 8] : 8'h00;

    always_comb begin
        req_ready      = '0;
        req_ready[g_q] = fire;
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomised and directed bench for uart_tx_arb against a transaction-level
// model of grants, byte slots and rotation.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int HT = 8;

    logic           ifclk = 1'b0;
    logic           resetb;
    logic           enable;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           we;
    logic           tx_busy;
    logic           tx_done;
    logic           grant_valid;
    logic [1:0]     grant_id;
    logic           timeout_pulse;

    always #5 ifclk = ~ifclk;

    uart_tx_arb #(.NUM_REQ(N), .MAX_BURST(MB), .HOLD_TIMEOUT(HT)) dut (
        .ifclk         (ifclk),
        .resetb        (resetb),
        .enable        (enable),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .we            (we),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .timeout_pulse (timeout_pulse)
    );

    int checks = 0;
    int errors = 0;

    // Per-requester byte sources: circular buffers of {last, data}
    logic [8:0] sbuf [N][64];
    int shead [N];
    int scnt  [N];

    // UART transmitter stand-in
    int ucnt = 0;
    int udly = 10;
    bit ustart = 0, spur_en = 0, force_busy = 0, en_drv = 1;

    // Reference model: owner of the transmitter, byte in flight, counts
    int m_owner = -1, m_ptr = 0, m_gid = 0, m_bytes = 0, m_low = 0;
    bit m_inflight = 0, m_lastflag = 0;
    bit chk_en = 0;
    int cyc = 0, last_done_cyc = 0, to_n = 0, to_gap = -1;
    logic [9:0] wlog [$];
    logic [9:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input bit l);
        sbuf[i][(shead[i] + scnt[i]) % 64] = {l, d};
        scnt[i]++;
    endtask

    task automatic ex(input logic [1:0] id, input logic [7:0] d);
        exp_q.push_back({id, d});
    endtask

    task automatic check_log(input string nm);
        chk($sformatf("%s_len", nm), wlog.size(), exp_q.size());
        for (int k = 0; k < wlog.size() && k < exp_q.size(); k++)
            chk($sformatf("%s_%0d", nm, k), wlog[k], exp_q[k]);
        wlog.delete();
        exp_q.delete();
    endtask

    task automatic drive();
        if (ustart) begin
            ucnt   = udly;
            ustart = 0;
        end
        tx_busy = (ucnt > 0) || force_busy || (spur_en && ucnt == 0 && $urandom_range(0, 7) == 0);
        tx_done = (ucnt == 1) || (spur_en && ucnt == 0 && $urandom_range(0, 9) == 0);
        if (ucnt > 0) ucnt--;
        enable = en_drv;
        for (int i = 0; i < N; i++) begin
            if (scnt[i] > 0) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = sbuf[i][shead[i]][7:0];
                req_last[i]        = sbuf[i][shead[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
    endtask

    task automatic step();
        @(negedge ifclk);
        for (int i = 0; i < N; i++)
            if (req_ready[i] === 1'b1 && scnt[i] > 0) begin
                shead[i] = (shead[i] + 1) % 64;
                scnt[i]--;
            end
        if (we === 1'b1) ustart = 1;
        @(posedge ifclk);
        #1;
        drive();
    endtask

    function automatic bit drained();
        bit d = (ucnt == 0) && !ustart;
        for (int i = 0; i < N; i++) if (scnt[i] != 0) d = 0;
        return d;
    endfunction

    task automatic run_idle(input int budget, input string nm);
        int n = 0;
        while (!(drained() && m_owner < 0) && n < budget) begin
            step();
            n++;
        end
        if (!(drained() && m_owner < 0)) begin
            checks++;
            errors++;
            $display("FAIL %s no idle within %0d cycles", nm, budget);
        end
        step();
        step();
    endtask

    // Checks the DUT outputs of the current cycle, then advances the model
    task automatic model_cycle();
        bit e_send, e_fire, e_to;
        int o;
        logic [7:0]   e_data;
        logic [N-1:0] e_ready;
        cyc++;
        o       = (m_owner < 0) ? 0 : m_owner;
        e_send  = (m_owner >= 0) && !m_inflight;
        e_fire  = e_send && req_valid[o] && !tx_busy;
        e_data  = e_send ? req_data[o*8 +: 8] : 8'h00;
        e_ready = '0;
        if (e_fire) e_ready[o] = 1'b1;
        e_to    = e_send && !req_valid[o] && (m_low == HT - 1);

        chk("we", we, e_fire);
        chk("req_ready", req_ready, e_ready);
        chk("tx_data", tx_data, e_data);
        chk("grant_valid", grant_valid, m_owner >= 0);
        chk("grant_id", grant_id, m_gid);
        chk("timeout_pulse", timeout_pulse, e_to);

        if (we === 1'b1) wlog.push_back({grant_id, tx_data});
        if (timeout_pulse === 1'b1) begin
            to_n++;
            to_gap = cyc - last_done_cyc;
        end

        if (m_owner < 0) begin
            if (enable)
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (req_valid[c] && m_owner < 0) begin
                        m_owner    = c;
                        m_gid      = c;
                        m_bytes    = 0;
                        m_low      = 0;
                        m_inflight = 0;
                    end
                end
        end else if (!m_inflight) begin
            if (e_fire) begin
                m_bytes++;
                m_lastflag = req_last[o];
                m_inflight = 1;
            end else if (!req_valid[o]) begin
                if (m_low == HT - 1) begin
                    m_ptr   = (o + 1) % N;
                    m_owner = -1;
                end else begin
                    m_low++;
                end
            end
        end else if (tx_done) begin
            last_done_cyc = cyc;
            m_inflight    = 0;
            if (m_lastflag || m_bytes == MB || !enable) begin
                m_ptr   = (o + 1) % N;
                m_owner = -1;
            end else begin
                m_low = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge ifclk);
            #3;
            if (chk_en) model_cycle();
        end
    end

    initial begin
        int to0, n;
        resetb = 1'b0; enable = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        for (int i = 0; i < N; i++) begin
            shead[i] = 0;
            scnt[i]  = 0;
        end
        #12;
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_timeout", timeout_pulse, 0);
        chk("rst_we", we, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_tx_data", tx_data, 0);
        resetb = 1'b1;
        @(posedge ifclk);
        #1;
        drive();
        chk_en = 1;

        // Fairness: 0, 2, 3 with single-byte packets, pointer wraps 3 -> 0
        for (int r = 0; r < 2; r++) begin
            push(0, 8'(r * 16 + 0), 1);
            push(2, 8'(r * 16 + 2), 1);
            push(3, 8'(r * 16 + 3), 1);
        end
        run_idle(400, "fair");
        ex(0, 8'h00); ex(2, 8'h02); ex(3, 8'h03);
        ex(0, 8'h10); ex(2, 8'h12); ex(3, 8'h13);
        check_log("fair");

        // Single packet on requester 1
        push(1, 8'h41, 0); push(1, 8'h42, 0); push(1, 8'h43, 1);
        run_idle(200, "single");
        ex(1, 8'h41); ex(1, 8'h42); ex(1, 8'h43);
        check_log("single");

        // Burst limit: requester 0 streams 10 bytes, requester 1 waits one turn
        to0 = to_n;
        for (int k = 0; k < 10; k++) push(0, 8'(8'h10 + k), 0);
        push(1, 8'hB1, 1);
        run_idle(600, "burst");
        for (int k = 0; k < 4; k++) ex(0, 8'(8'h10 + k));
        ex(1, 8'hB1);
        for (int k = 4; k < 10; k++) ex(0, 8'(8'h10 + k));
        check_log("burst");
        chk("burst_timeouts", to_n - to0, 1);

        // Hold timeout: requester 2 goes silent mid-packet, grant passes to 3
        to0 = to_n;
        push(2, 8'h5A, 0); push(3, 8'h33, 1); push(0, 8'h30, 1);
        run_idle(300, "hold");
        ex(2, 8'h5A); ex(3, 8'h33); ex(0, 8'h30);
        check_log("hold");
        chk("hold_timeouts", to_n - to0, 1);
        chk("hold_gap", to_gap, 8);

        // Enable dropped while a byte is in flight
        push(1, 8'hE1, 0); push(1, 8'hE2, 0); push(1, 8'hE3, 1);
        n = 0;
        while (wlog.size() == 0 && n < 50) begin
            step();
            n++;
        end
        chk("en_first_we_seen", wlog.size(), 1);
        en_drv = 0;
        for (int k = 0; k < 20; k++) step();
        chk("en_no_new_we", wlog.size(), 1);
        chk("en_grant_released", grant_valid, 0);
        en_drv = 1;
        run_idle(300, "enable");
        ex(1, 8'hE1); ex(1, 8'hE2); ex(1, 8'hE3);
        check_log("enable");

        // Random traffic with spurious busy/done and enable glitches
        spur_en = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (scnt[i] < 6 && $urandom_range(0, 5) == 0)
                    push(i, 8'($urandom), $urandom_range(0, 2) == 0);
            en_drv = ($urandom_range(0, 19) != 0);
            udly   = $urandom_range(1, 6);
            step();
        end
        spur_en = 0;
        en_drv  = 1;
        run_idle(3000, "random");
        wlog.delete();

        // Asynchronous reset while granted and held off by a busy UART
        force_busy = 1;
        push(2, 8'h77, 0);
        n = 0;
        while (m_owner < 0 && n < 20) begin
            step();
            n++;
        end
        step();
        step();
        chk("pre_rst_grant_valid", grant_valid, 1);
        chk("pre_rst_grant_id", grant_id, 2);
        chk("pre_rst_tx_data", tx_data, 8'h77);
        chk_en = 0;
        #2;
        resetb = 1'b0;
        #1;
        chk("mid_rst_grant_valid", grant_valid, 0);
        chk("mid_rst_grant_id", grant_id, 0);
        chk("mid_rst_timeout", timeout_pulse, 0);
        chk("mid_rst_we", we, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_tx_data", tx_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
